// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the UART program loader.
// State and TX-sequencer encodings, boot/ready byte defaults, bytes per imem word.
package uart_loader_pkg;

    localparam logic [7:0]  BOOT_BYTE_DEF  = 8'h99;
    localparam logic [7:0]  READY_BYTE_DEF = 8'hAA;
    localparam int unsigned WORD_BYTES     = 4;

    typedef enum logic [2:0] {
        SEND_BOOT,
        SIZE,
        PROG,
        SEND_SUM,
        SEND_READY,
        RUN,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_GUARD,
        TX_WAIT
    } tx_state_t;

endpackage

// File: rtl/uart_tx_sequencer.sv
// Launches one byte on UART_TX: one-cycle tx_start, a guard cycle where tx_busy is
// ignored, then waits for tx_busy low. send_ack marks launch, send_done marks line free.
module uart_tx_sequencer
    import uart_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       send_req,
    input  logic [7:0] send_byte,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_sdata,
    output logic       send_ack,
    output logic       send_done
);

    tx_state_t state, next_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            tx_sdata <= '0;
        end else begin
            state <= next_state;
            if (send_ack) begin
                tx_sdata <= send_byte;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            TX_IDLE:  if (send_req && !tx_busy) next_state = TX_START;
            TX_START: next_state = TX_GUARD;
            TX_GUARD: next_state = TX_WAIT;
            TX_WAIT:  if (!tx_busy) next_state = TX_IDLE;
            default:  next_state = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_start  = (state == TX_START);
        send_ack  = (state == TX_IDLE) && send_req && !tx_busy;
        send_done = (state == TX_WAIT) && !tx_busy;
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot sequencer: sends BOOT_BYTE, receives size and program into imem, sends READY_BYTE,
// then releases the core. Define UART_PROGRAM_LOADER_CHECKSUM_EN to send a byte sum first.
module uart_program_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_WIDTH = 14,
    parameter logic [7:0]  BOOT_BYTE       = BOOT_BYTE_DEF,
    parameter logic [7:0]  READY_BYTE      = READY_BYTE_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 rx_rdata,
    input  logic                       rx_rdata_ready,
    input  logic                       rx_ferr,
    output logic [7:0]                 tx_sdata,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       uart_owned,
    output logic                       core_run,
    output logic                       load_err
);

    localparam logic [32:0] CAPACITY = 33'(WORD_BYTES) << IMEM_ADDR_WIDTH;

`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_PROG = SEND_SUM;
    logic [7:0] sum;
`else
    localparam state_t AFTER_PROG = SEND_READY;
`endif

    state_t      state, next_state;
    logic [31:0] count;
    logic [31:0] size;
    logic [31:0] word_buf;
    logic        ready_sent;
    logic        send_req;
    logic [7:0]  send_byte;
    logic        send_ack;
    logic        send_done;
    logic        rx_ok;
    logic [1:0]  lane;
    logic        last_byte;
    logic [31:0] size_full;
    logic [31:0] word;

    assign rx_ok     = rx_rdata_ready && !rx_ferr;
    assign lane      = count[1:0];
    assign last_byte = (count == size - 32'd1);
    assign size_full = {rx_rdata, size[23:0]};
    // Upper lanes of word_buf are always zero, which gives the padding of a partial word.
    assign word      = word_buf | ({24'b0, rx_rdata} << {lane, 3'b000});

    uart_tx_sequencer u_tx_seq (
        .clk       (clk),
        .reset     (reset),
        .send_req  (send_req),
        .send_byte (send_byte),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_sdata  (tx_sdata),
        .send_ack  (send_ack),
        .send_done (send_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEND_BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            SEND_BOOT: if (send_ack) next_state = SIZE;
            SIZE: begin
                if (rx_rdata_ready) begin
                    if (rx_ferr) begin
                        next_state = ERROR;
                    end else if (lane == 2'd3) begin
                        if (size_full == 32'd0) begin
                            next_state = AFTER_PROG;
                        end else if ({1'b0, size_full} > CAPACITY) begin
                            next_state = ERROR;
                        end else begin
                            next_state = PROG;
                        end
                    end
                end
            end
            PROG: begin
                if (rx_rdata_ready) begin
                    if (rx_ferr) begin
                        next_state = ERROR;
                    end else if (last_byte) begin
                        next_state = AFTER_PROG;
                    end
                end
            end
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
            SEND_SUM: if (send_ack) next_state = SEND_READY;
`endif
            // ready_sent keeps a trailing send_done from an earlier byte from ending this state.
            SEND_READY: if (ready_sent && send_done) next_state = RUN;
            default: next_state = state;
        endcase
    end

    always_comb begin
        uart_owned = 1'b1;
        core_run   = 1'b0;
        load_err   = 1'b0;
        send_req   = 1'b0;
        send_byte  = BOOT_BYTE;
        case (state)
            SEND_BOOT: send_req = 1'b1;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
            SEND_SUM: begin
                send_req  = 1'b1;
                send_byte = sum;
            end
`endif
            SEND_READY: begin
                send_req  = !ready_sent;
                send_byte = READY_BYTE;
            end
            RUN: begin
                uart_owned = 1'b0;
                core_run   = 1'b1;
            end
            ERROR: load_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            size       <= '0;
            word_buf   <= '0;
            ready_sent <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (state == SEND_READY && send_ack) begin
                ready_sent <= 1'b1;
            end
            case (state)
                SIZE: begin
                    if (rx_ok) begin
                        size[{lane, 3'b000} +: 8] <= rx_rdata;
                        count    <= (lane == 2'd3) ? '0 : count + 32'd1;
                        word_buf <= '0;
                    end
                end
                PROG: begin
                    if (rx_ok) begin
                        count <= count + 32'd1;
`ifdef UART_PROGRAM_LOADER_CHECKSUM_EN
                        sum   <= sum + rx_rdata;
`endif
                        if (lane == 2'd3 || last_byte) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= count[IMEM_ADDR_WIDTH+1:2];
                            imem_wdata <= word;
                            word_buf   <= '0;
                        end else begin
                            word_buf <= word;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
